// File: rtl/cdda_pkg.sv
// Shared definitions for the CDDA sector streamer.
//   SECTOR_BYTES          default raw CDDA sector size in bytes (even, < 4096)
//   CDDA_WORDS_PER_SECTOR 16-bit FIFO words produced per full sector
//   BCNT_W                width of the per-sector byte counter
//   state_e               streamer FSM states
package cdda_pkg;

  localparam int SECTOR_BYTES          = 2352;
  localparam int CDDA_WORDS_PER_SECTOR = SECTOR_BYTES / 2;
  localparam int BCNT_W                = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_REQ = 3'd1,
    ST_REQ      = 3'd2,
    ST_XFER     = 3'd3,
    ST_NEXT     = 3'd4,
    ST_DRAIN    = 3'd5
  } state_e;

endpackage

// File: rtl/cdda_word_packer.sv
// Packs a byte stream into 16-bit words and presents them to the CDDA FIFO.
// The first byte of each pair lands in [15:8], the second in [7:0].
// Ports:
//   clk_sys, reset  system clock, synchronous active-high reset
//   clk_en_i        FIFO write qualifier; a pending word retires on a cycle
//                   where it is high
//   clear_i         drop any half-assembled word (byte phase back to even)
//   enable_i        accept bytes; low while bytes are being discarded
//   byte_wr_i       byte strobe
//   byte_i          byte data
//   wr_o            word valid towards the FIFO
//   word_o          word data, stable while wr_o is high
//   ovf_o           a word completed while the previous one was still pending
module cdda_word_packer
  import cdda_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        clk_en_i,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic        byte_wr_i,
  input  logic [7:0]  byte_i,
  output logic        wr_o,
  output logic [15:0] word_o,
  output logic        ovf_o
);

  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic        pend_q, pend_d;
  logic [15:0] word_q, word_d;
  logic        take;

  always_comb begin
    take    = byte_wr_i & enable_i;
    phase_d = phase_q;
    hi_d    = hi_q;
    word_d  = word_q;
    pend_d  = pend_q;

    // The FIFO samples the word on this cycle, so it is gone next cycle.
    if (pend_q && clk_en_i) pend_d = 1'b0;

    if (clear_i) begin
      phase_d = 1'b0;
    end else if (take) begin
      if (!phase_q) begin
        hi_d    = byte_i;
        phase_d = 1'b1;
      end else begin
        word_d  = {hi_q, byte_i};
        pend_d  = 1'b1;
        phase_d = 1'b0;
      end
    end

    // Overwriting a word that the FIFO has not yet taken loses it; a word
    // retiring in this very cycle is not lost.
    ovf_o = take & phase_q & ~clear_i & pend_q & ~clk_en_i;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
      pend_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
      pend_q  <= pend_d;
      word_q  <= word_d;
    end
  end

  assign wr_o   = pend_q;
  assign word_o = word_q;

endmodule

// File: rtl/cdda_sector_streamer.sv
// Steps through an inclusive LBA range, requests each raw CDDA sector from
// the host byte interface and streams it as 16-bit words into the CDDA FIFO.
// Ports:
//   clk_sys, reset          system clock, synchronous active-high reset
//   clk_en                  FIFO write qualifier
//   cmd_play, cmd_stop      one-cycle command pulses (stop wins when both)
//   start_lba, end_lba      range, sampled on an accepted cmd_play
//   playing, done           status; done pulses once after the last sector
//   cur_lba                 sector currently requested or in transfer
//   err_short, err_ovf      sticky error flags, cleared by cmd_play
//   sd_rd, sd_lba           sector read request towards the host
//   sd_ack, sd_buff_wr,
//   sd_buff_dout            host transfer window and byte stream
//   hdd_cdda_req            FIFO has room for a whole sector
//   hdd_cdda_wr,
//   hdd_data_out            word handshake towards the FIFO
module cdda_sector_streamer
  import cdda_pkg::*;
#(
  parameter int SECTOR_BYTES = cdda_pkg::SECTOR_BYTES,
  parameter int LBA_W        = 24
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             cmd_play,
  input  logic             cmd_stop,
  input  logic [LBA_W-1:0] start_lba,
  input  logic [LBA_W-1:0] end_lba,
  output logic             playing,
  output logic             done,
  output logic [LBA_W-1:0] cur_lba,
  output logic             err_short,
  output logic             err_ovf,
  output logic             sd_rd,
  output logic [LBA_W-1:0] sd_lba,
  input  logic             sd_ack,
  input  logic             sd_buff_wr,
  input  logic [7:0]       sd_buff_dout,
  input  logic             hdd_cdda_req,
  output logic             hdd_cdda_wr,
  output logic [15:0]      hdd_data_out
);

  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(SECTOR_BYTES - 1);

  state_e             state_q, state_d;
  logic [LBA_W-1:0]   cur_lba_q, cur_lba_d;
  logic [LBA_W-1:0]   end_lba_q, end_lba_d;
  logic [LBA_W-1:0]   nxt_lba_q, nxt_lba_d;
  logic               restart_q, restart_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic               full_q, full_d;
  logic               playing_q, playing_d;
  logic               err_short_q, err_short_d;
  logic               err_ovf_q, err_ovf_d;
  logic               sd_rd_q;

  logic               play_ok;
  logic               abort;
  logic               load;
  logic               byte_last;
  logic               full_now;
  logic               done_c;
  logic               pk_clear;
  logic               pk_enable;
  logic               pk_ovf;

  // A play with an empty range is ignored; stop overrides a simultaneous play.
  assign play_ok = cmd_play & ~cmd_stop & (start_lba <= end_lba);
  assign abort   = cmd_stop | cmd_play;

  always_comb begin
    state_d     = state_q;
    cur_lba_d   = cur_lba_q;
    end_lba_d   = end_lba_q;
    nxt_lba_d   = nxt_lba_q;
    restart_d   = restart_q;
    bcnt_d      = bcnt_q;
    full_d      = full_q;
    playing_d   = playing_q;
    err_short_d = err_short_q;
    load        = 1'b0;
    done_c      = 1'b0;
    pk_clear    = 1'b0;
    pk_enable   = 1'b0;
    byte_last   = (bcnt_q == LAST_BYTE);
    // The final byte and the fall of sd_ack may arrive in the same cycle.
    full_now    = full_q | (sd_buff_wr & byte_last);

    unique case (state_q)
      ST_IDLE: begin
        if (play_ok) load = 1'b1;
      end

      ST_WAIT_REQ, ST_REQ: begin
        if (abort) begin
          if (play_ok) begin
            load = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            playing_d = 1'b0;
          end
        end else if (state_q == ST_WAIT_REQ) begin
          if (hdd_cdda_req) state_d = ST_REQ;
        end else if (sd_ack) begin
          state_d  = ST_XFER;
          bcnt_d   = '0;
          full_d   = 1'b0;
          pk_clear = 1'b1;
        end
      end

      ST_XFER: begin
        if (abort) begin
          // The host cannot be cut off mid-sector, so the rest is drained;
          // an accepted play restarts once the host releases sd_ack.
          state_d   = ST_DRAIN;
          playing_d = play_ok;
          restart_d = play_ok;
          if (play_ok) begin
            nxt_lba_d = start_lba;
            end_lba_d = end_lba;
          end
        end else begin
          pk_enable = 1'b1;
          if (sd_buff_wr) begin
            bcnt_d = byte_last ? '0 : bcnt_q + 1'b1;
            if (byte_last) full_d = 1'b1;
          end
          if (!sd_ack) begin
            state_d = ST_NEXT;
            if (!full_now) begin
              err_short_d = 1'b1;
              pk_clear    = 1'b1;
            end
          end
        end
      end

      ST_NEXT: begin
        if (abort) begin
          if (play_ok) begin
            load = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            playing_d = 1'b0;
          end
        end else if (cur_lba_q == end_lba_q) begin
          done_c    = 1'b1;
          playing_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cur_lba_d = cur_lba_q + 1'b1;
          state_d   = ST_WAIT_REQ;
        end
      end

      ST_DRAIN: begin
        if (cmd_stop) begin
          restart_d = 1'b0;
          playing_d = 1'b0;
        end else if (cmd_play) begin
          restart_d = play_ok;
          playing_d = play_ok;
          if (play_ok) begin
            nxt_lba_d = start_lba;
            end_lba_d = end_lba;
          end
        end
        if (!sd_ack) begin
          if (restart_d) begin
            state_d   = ST_WAIT_REQ;
            cur_lba_d = nxt_lba_d;
          end else begin
            state_d = ST_IDLE;
          end
          restart_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d   = ST_WAIT_REQ;
      cur_lba_d = start_lba;
      end_lba_d = end_lba;
      playing_d = 1'b1;
    end

    if (play_ok) err_short_d = 1'b0;
  end

  // Kept apart from the FSM block: pk_ovf depends on pk_enable.
  always_comb begin
    err_ovf_d = err_ovf_q | pk_ovf;
    if (play_ok) err_ovf_d = 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_lba_q   <= '0;
      end_lba_q   <= '0;
      nxt_lba_q   <= '0;
      restart_q   <= 1'b0;
      bcnt_q      <= '0;
      full_q      <= 1'b0;
      playing_q   <= 1'b0;
      err_short_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      sd_rd_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_lba_q   <= cur_lba_d;
      end_lba_q   <= end_lba_d;
      nxt_lba_q   <= nxt_lba_d;
      restart_q   <= restart_d;
      bcnt_q      <= bcnt_d;
      full_q      <= full_d;
      playing_q   <= playing_d;
      err_short_q <= err_short_d;
      err_ovf_q   <= err_ovf_d;
      // Registered from the next state so the request tracks REQ exactly.
      sd_rd_q     <= (state_d == ST_REQ);
    end
  end

  cdda_word_packer u_packer (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .clk_en_i  (clk_en),
    .clear_i   (pk_clear),
    .enable_i  (pk_enable),
    .byte_wr_i (sd_buff_wr),
    .byte_i    (sd_buff_dout),
    .wr_o      (hdd_cdda_wr),
    .word_o    (hdd_data_out),
    .ovf_o     (pk_ovf)
  );

  assign playing   = playing_q;
  assign done      = done_c;
  assign cur_lba   = cur_lba_q;
  assign sd_lba    = cur_lba_q;
  assign sd_rd     = sd_rd_q;
  assign err_short = err_short_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_cdda_sector_streamer.sv
module tb_cdda_sector_streamer;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b1;
  logic        cmd_play = 1'b0;
  logic        cmd_stop = 1'b0;
  logic [23:0] start_lba = '0;
  logic [23:0] end_lba = '0;
  logic        playing, done, err_short, err_ovf, sd_rd, hdd_cdda_wr;
  logic [23:0] cur_lba, sd_lba;
  logic [15:0] hdd_data_out;
  logic        sd_ack = 1'b0;
  logic        sd_buff_wr = 1'b0;
  logic [7:0]  sd_buff_dout = '0;
  logic        hdd_cdda_req = 1'b0;

  always #5 clk_sys = ~clk_sys;

  cdda_sector_streamer dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .clk_en       (clk_en),
    .cmd_play     (cmd_play),
    .cmd_stop     (cmd_stop),
    .start_lba    (start_lba),
    .end_lba      (end_lba),
    .playing      (playing),
    .done         (done),
    .cur_lba      (cur_lba),
    .err_short    (err_short),
    .err_ovf      (err_ovf),
    .sd_rd        (sd_rd),
    .sd_lba       (sd_lba),
    .sd_ack       (sd_ack),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_dout (sd_buff_dout),
    .hdd_cdda_req (hdd_cdda_req),
    .hdd_cdda_wr  (hdd_cdda_wr),
    .hdd_data_out (hdd_data_out)
  );

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] w;
  } pair_t;

  pair_t       tbl[6];
  logic [15:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          rd_rise = 0;
  int          hold_cycles = 0;
  int          ce_cnt = 0;
  bit          ce_mode = 1'b0;
  bit          rd_prev = 1'b0;
  bit          hold_q = 1'b0;
  logic [15:0] hold_data = '0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [7:0] pat(input int lba, input int i);
    return 8'((lba * 37 + i * 13 + (i >> 7)) & 255);
  endfunction

  // One clock: sample/score at the falling edge, return just after the rising edge.
  task automatic tick();
    logic [15:0] w;
    @(negedge clk_sys);
    if (!reset) begin
      if (hdd_cdda_wr && hold_q) chk("held_word_stable", hdd_data_out, hold_data);
      if (hdd_cdda_wr && !clk_en) hold_cycles++;
      if (hdd_cdda_wr && clk_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(hdd_data_out), 32'hFFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          chk("word", hdd_data_out, w);
        end
      end
      hold_q    = hdd_cdda_wr && !clk_en;
      hold_data = hdd_data_out;
      if (done) done_cnt++;
      if (sd_rd && !rd_prev) rd_rise++;
      rd_prev = sd_rd;
    end
    @(posedge clk_sys);
    #1;
    ce_cnt++;
    clk_en = (ce_mode == 1'b0) || (ce_cnt % 4 == 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sd_rd"}, sd_rd, 0);
    chk({tag, "_wr"}, hdd_cdda_wr, 0);
    chk({tag, "_data"}, hdd_data_out, 0);
    chk({tag, "_playing"}, playing, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cur_lba"}, cur_lba, 0);
    chk({tag, "_err_short"}, err_short, 0);
    chk({tag, "_err_ovf"}, err_ovf, 0);
  endtask

  task automatic play(input int s, input int e);
    start_lba = 24'(s);
    end_lba   = 24'(e);
    cmd_play  = 1'b1;
    tick();
    cmd_play  = 1'b0;
  endtask

  // Host model: waits for the request, opens sd_ack and streams bytes.
  task automatic host_sector(input int lba, input int nbytes, input int gap,
                             input bit use_tbl, input int stop_at, input int rst_at);
    int t;
    logic [7:0] b, prev;
    t = 0;
    prev = '0;
    while (!sd_rd && t < 20000) begin
      tick();
      t++;
    end
    chk("sd_rd_seen", sd_rd, 1);
    if (!sd_rd) return;
    chk("sd_lba", sd_lba, 32'(lba));
    sd_ack = 1'b1;
    tick();
    for (int i = 0; i < nbytes; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        tick();
        check_reset_vals("rst_xfer");
        reset   = 1'b0;
        sd_ack  = 1'b0;
        exp_q.delete();
        hold_q  = 1'b0;
        rd_prev = 1'b0;
        return;
      end
      if (i == stop_at) begin
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        chk("stop_playing", playing, 0);
      end
      if (use_tbl && i < 12) b = i[0] ? tbl[i/2].b1 : tbl[i/2].b0;
      else                   b = pat(lba, i);
      if (i[0] && (stop_at < 0 || i < stop_at)) begin
        if (use_tbl && i < 12) exp_q.push_back(tbl[i/2].w);
        else                   exp_q.push_back({prev, b});
      end
      prev = b;
      sd_buff_wr   = 1'b1;
      sd_buff_dout = b;
      tick();
      sd_buff_wr = 1'b0;
      repeat (gap) tick();
    end
    sd_ack = 1'b0;
  endtask

  initial begin
    int  w0, d0, r0;
    bit  rd_bad;

    tbl[0] = '{8'h34, 8'h12, 16'h3412};
    tbl[1] = '{8'h00, 8'hFF, 16'h00FF};
    tbl[2] = '{8'hFF, 8'h00, 16'hFF00};
    tbl[3] = '{8'hA5, 8'h5A, 16'hA55A};
    tbl[4] = '{8'h80, 8'h01, 16'h8001};
    tbl[5] = '{8'hFF, 8'hFF, 16'hFFFF};

    // Reset state
    repeat (3) tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    // Two-sector range, table bytes at the head of the first sector
    hdd_cdda_req = 1'b1;
    w0 = wr_cnt; d0 = done_cnt; r0 = rd_rise;
    play(100, 101);
    chk("t1_playing", playing, 1);
    host_sector(100, 2352, 0, 1'b1, -1, -1);
    host_sector(101, 2352, 0, 1'b0, -1, -1);
    repeat (10) tick();
    chk("t1_writes", wr_cnt - w0, 2352);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_playing_end", playing, 0);
    chk("t1_requests", rd_rise - r0, 2);
    chk("t1_queue", exp_q.size(), 0);
    chk("t1_err_ovf", err_ovf, 0);
    chk("t1_err_short", err_short, 0);
    chk("t1_cur_lba", cur_lba, 101);

    // Sparse clk_en: words held until the qualifying cycle
    ce_mode = 1'b1;
    w0 = wr_cnt; d0 = done_cnt; hold_cycles = 0;
    play(200, 200);
    host_sector(200, 2352, 3, 1'b1, -1, -1);
    repeat (20) tick();
    ce_mode = 1'b0;
    chk("t2_writes", wr_cnt - w0, 1176);
    chk("t2_held", hold_cycles > 0, 1);
    chk("t2_err_ovf", err_ovf, 0);
    chk("t2_done", done_cnt - d0, 1);
    chk("t2_queue", exp_q.size(), 0);

    // FIFO not ready between sectors
    w0 = wr_cnt; d0 = done_cnt;
    play(300, 301);
    host_sector(300, 2352, 0, 1'b0, -1, -1);
    hdd_cdda_req = 1'b0;
    rd_bad = 1'b0;
    repeat (500) begin
      tick();
      if (sd_rd) rd_bad = 1'b1;
    end
    chk("t3_rd_low", rd_bad, 0);
    hdd_cdda_req = 1'b1;
    chk("t3_rd_before", sd_rd, 0);
    tick();
    chk("t3_rd_after", sd_rd, 1);
    host_sector(301, 2352, 0, 1'b0, -1, -1);
    repeat (10) tick();
    chk("t3_writes", wr_cnt - w0, 2352);
    chk("t3_done", done_cnt - d0, 1);

    // Stop in the middle of a sector
    w0 = wr_cnt; d0 = done_cnt; r0 = rd_rise;
    play(400, 402);
    host_sector(400, 2352, 0, 1'b0, 1000, -1);
    repeat (50) tick();
    chk("t4_writes", wr_cnt - w0, 500);
    chk("t4_done", done_cnt - d0, 0);
    chk("t4_requests", rd_rise - r0, 1);
    chk("t4_sd_rd", sd_rd, 0);
    chk("t4_playing", playing, 0);
    chk("t4_queue", exp_q.size(), 0);

    // Short sector, then an empty range that must be ignored
    w0 = wr_cnt; d0 = done_cnt;
    play(500, 501);
    host_sector(500, 101, 0, 1'b1, -1, -1);
    repeat (3) tick();
    chk("t5_err_short", err_short, 1);
    chk("t5_writes_short", wr_cnt - w0, 50);
    host_sector(501, 2352, 0, 1'b0, -1, -1);
    repeat (10) tick();
    chk("t5_writes", wr_cnt - w0, 1226);
    chk("t5_done", done_cnt - d0, 1);
    chk("t5_err_sticky", err_short, 1);
    r0 = rd_rise;
    play(10, 5);
    chk("t5_bad_range_playing", playing, 0);
    repeat (20) tick();
    chk("t5_bad_range_rd", rd_rise - r0, 0);
    chk("t5_bad_range_lba", cur_lba, 501);
    chk("t5_bad_range_err", err_short, 1);

    // Reset in the middle of a transfer, then a normal run
    play(600, 600);
    host_sector(600, 2352, 0, 1'b0, -1, 500);
    repeat (3) tick();
    w0 = wr_cnt; d0 = done_cnt;
    play(700, 700);
    host_sector(700, 2352, 0, 1'b0, -1, -1);
    repeat (10) tick();
    chk("t6_writes", wr_cnt - w0, 1176);
    chk("t6_done", done_cnt - d0, 1);
    chk("t6_queue", exp_q.size(), 0);
    chk("t6_err_short", err_short, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
